// File: rtl/wb_write_queue.sv
// In-order write-back queue in front of the single register-file write port.
// Merges load and ALU results (load first) and answers two pending-write queries from decode.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          mem_valid,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_data,
  output logic          mem_ready,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  input  logic [AW-1:0] q_addr1,
  output logic          q_pend1,
  output logic [DW-1:0] q_data1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_pend2,
  output logic [DW-1:0] q_data2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] qa [DEPTH];
  logic [DW-1:0] qd [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          pop;
  logic [CW-1:0] free;
  logic          mem_nz;
  logic          mem_push;
  logic          alu_push;

  // The head always drains, so a full queue still frees one slot this cycle.
  always_comb begin
    pop       = (count != '0);
    free      = CW'(DEPTH) - count + CW'(pop);
    mem_nz    = mem_valid && (mem_addr != '0);
    mem_ready = !rst && (free >= CW'(1));
    alu_ready = !rst && (free >= (CW'(1) + CW'(mem_nz)));
    mem_push  = mem_valid && mem_ready && (mem_addr != '0);
    alu_push  = alu_valid && alu_ready && (alu_addr != '0);
  end

  // Stage boundary: queue head -> register-file port, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      we <= pop;
      if (pop) begin
        waddr <= qa[head];
        wdata <= qd[head];
        head  <= head + PW'(1);
      end
      tail  <= tail + PW'(mem_push) + PW'(alu_push);
      count <= count - CW'(pop) + CW'(mem_push) + CW'(alu_push);
    end
  end

  // Queue storage carries no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (mem_push) begin
      qa[tail] <= mem_addr;
      qd[tail] <= mem_data;
    end
    if (alu_push) begin
      qa[tail + PW'(mem_push)] <= alu_addr;
      qd[tail + PW'(mem_push)] <= alu_data;
    end
  end

  // Walk oldest to youngest so the last match wins; the output register is not searched.
  always_comb begin
    q_pend1 = 1'b0;
    q_data1 = '0;
    q_pend2 = 1'b0;
    q_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if ((q_addr1 != '0) && (qa[head + PW'(i)] == q_addr1)) begin
          q_pend1 = 1'b1;
          q_data1 = qd[head + PW'(i)];
        end
        if ((q_addr2 != '0) && (qa[head + PW'(i)] == q_addr2)) begin
          q_pend2 = 1'b1;
          q_data2 = qd[head + PW'(i)];
        end
      end
    end
    if (rst) begin
      q_pend1 = 1'b0;
      q_data1 = '0;
      q_pend2 = 1'b0;
      q_data2 = '0;
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: ordering, backpressure, x0 drop, query forwarding, reset.
module tb_wb_write_queue;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid;
  logic [AW-1:0] alu_addr, mem_addr, q_addr1, q_addr2;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready, we, q_pend1, q_pend2;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata, q_data1, q_data2;

  int checks   = 0;
  int failures = 0;
  logic [AW+DW-1:0] wlog [$];
  logic [AW+DW-1:0] exp_w [$];

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .q_addr1(q_addr1), .q_pend1(q_pend1), .q_data1(q_data1),
    .q_addr2(q_addr2), .q_pend2(q_pend2), .q_data2(q_data2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (we === 1'b1) wlog.push_back({waddr, wdata});
  endtask

  task automatic idle;
    alu_valid = 1'b0; mem_valid = 1'b0;
    alu_addr = '0; alu_data = '0; mem_addr = '0; mem_data = '0;
  endtask

  initial begin
    rst = 1'b1; q_addr1 = '0; q_addr2 = '0;
    idle();
    #1;
    check("rst_mem_ready", 64'(mem_ready), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd0);
    tick(); tick();
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_count", 64'(dut.count), 64'd0);
    rst = 1'b0;
    tick();

    // T1 single write
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    #1 check("t1_alu_ready", 64'(alu_ready), 64'd1);
    tick(); idle();
    check("t1_we_edge0", 64'(we), 64'd0);
    tick();
    check("t1_we", 64'(we), 64'd1);
    check("t1_waddr", 64'(waddr), 64'd5);
    check("t1_wdata", 64'(wdata), 64'hDEADBEEF);
    tick();
    check("t1_we_off", 64'(we), 64'd0);

    // T2 ordering
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h11;
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h22;
    #1;
    check("t2_mem_ready", 64'(mem_ready), 64'd1);
    check("t2_alu_ready", 64'(alu_ready), 64'd1);
    tick(); idle();
    check("t2_count", 64'(dut.count), 64'd2);
    tick();
    check("t2_w1_we", 64'(we), 64'd1);
    check("t2_w1", 64'({waddr, wdata}), 64'({5'd3, 32'h11}));
    tick();
    check("t2_w2_we", 64'(we), 64'd1);
    check("t2_w2", 64'({waddr, wdata}), 64'({5'd4, 32'h22}));
    tick();
    check("t2_we_off", 64'(we), 64'd0);

    // T3 backpressure: ALU is refused once the queue is full
    wlog.delete();
    for (int i = 0; i < 6; i++) begin
      mem_valid = 1'b1; mem_addr = AW'(8 + i);  mem_data = 32'h100 + DW'(i);
      alu_valid = 1'b1; alu_addr = AW'(16 + i); alu_data = 32'h200 + DW'(i);
      #1;
      check($sformatf("t3_mem_ready_%0d", i), 64'(mem_ready), 64'd1);
      check($sformatf("t3_alu_ready_%0d", i), 64'(alu_ready), (i < 3) ? 64'd1 : 64'd0);
      if (i >= 3) check($sformatf("t3_count_%0d", i), 64'(dut.count), 64'd4);
      exp_w.push_back({AW'(8 + i), 32'h100 + DW'(i)});
      if (i < 3) exp_w.push_back({AW'(16 + i), 32'h200 + DW'(i)});
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) tick();
    check("t3_nwrites", 64'(wlog.size()), 64'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < wlog.size()) check($sformatf("t3_write_%0d", i), 64'(wlog[i]), 64'(exp_w[i]));
    end

    // T4 x0 drop
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFF;
    #1 check("t4_alu_ready", 64'(alu_ready), 64'd1);
    tick(); idle();
    check("t4_count", 64'(dut.count), 64'd0);
    check("t4_we0", 64'(we), 64'd0);
    tick();
    check("t4_we1", 64'(we), 64'd0);

    // T5 query forwarding
    q_addr1 = 5'd7; q_addr2 = 5'd0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hA;
    tick();
    alu_data = 32'hB;
    tick(); idle();
    #1;
    check("t5_pend1", 64'(q_pend1), 64'd1);
    check("t5_data1", 64'(q_data1), 64'hB);
    check("t5_pend2", 64'(q_pend2), 64'd0);
    check("t5_data2", 64'(q_data2), 64'd0);
    check("t5_port_a", 64'({we, waddr, wdata}), 64'({1'b1, 5'd7, 32'hA}));
    tick();
    check("t5_port_b", 64'({we, waddr, wdata}), 64'({1'b1, 5'd7, 32'hB}));
    check("t5_pend1_gone", 64'(q_pend1), 64'd0);
    check("t5_data1_gone", 64'(q_data1), 64'd0);
    mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hC;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'hD;
    tick(); idle();
    #1;
    check("t5_count2", 64'(dut.count), 64'd2);
    check("t5_young_pend", 64'(q_pend1), 64'd1);
    check("t5_young_data", 64'(q_data1), 64'hD);
    for (int i = 0; i < 4; i++) tick();

    // T6 reset mid-operation
    mem_valid = 1'b1; mem_addr = 5'd9;  mem_data = 32'h91;
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA0;
    tick();
    mem_addr = 5'd12; mem_data = 32'hC0;
    alu_addr = 5'd13; alu_data = 32'hD0;
    tick(); idle();
    q_addr1 = 5'd12;
    #1;
    check("t6_count3", 64'(dut.count), 64'd3);
    check("t6_pend_pre", 64'(q_pend1), 64'd1);
    check("t6_data_pre", 64'(q_data1), 64'hC0);
    rst = 1'b1;
    #1;
    check("t6_rst_mem_ready", 64'(mem_ready), 64'd0);
    check("t6_rst_alu_ready", 64'(alu_ready), 64'd0);
    check("t6_rst_pend", 64'(q_pend1), 64'd0);
    tick();
    check("t6_we", 64'(we), 64'd0);
    check("t6_waddr", 64'(waddr), 64'd0);
    check("t6_wdata", 64'(wdata), 64'd0);
    check("t6_count", 64'(dut.count), 64'd0);
    wlog.delete();
    rst = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h1;
    #1 check("t6_alu_ready", 64'(alu_ready), 64'd1);
    tick(); idle();
    check("t6_we_edge0", 64'(we), 64'd0);
    tick();
    check("t6_port", 64'({we, waddr, wdata}), 64'({1'b1, 5'd1, 32'h1}));
    tick();
    check("t6_we_off", 64'(we), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("t6_nwrites", 64'(wlog.size()), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
